expr_tx: RTL and testbench

EXPR_TX -- requirements
Module: expr_tx

---
 rtl/expr_tx.sv | 99 +++++++++
 tb/tb_expr_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/expr_tx.sv
// expr_tx: buffers up to 16 calculator tokens, streams them as ASCII followed by '=', then waits for the result.
// Define EXPR_TX_TIMEOUT_EN to add a 64-cycle watchdog on the result wait.
module expr_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic       tok_wr,
   input  logic [4:0] tok_in,
   input  logic       start,
   output logic [7:0] ascii_out,
   output logic       ready,
   input  logic       valid_in,
   input  logic [6:0] result_in,
   output logic       busy,
   output logic       done,
   output logic [6:0] result_out,
   output logic       err,
   output logic       timeout
);
   typedef enum logic [2:0] {IDLE, SEND, TERM, WAIT, DONE} state_t;
   state_t     r_state, w_next;
   logic [4:0] r_buf [16];
   logic [4:0] r_count;
   logic [3:0] r_idx;
   logic [6:0] r_result;
   logic       r_err;
   logic [4:0] w_tok;
   logic       w_start, w_wr, w_store, w_last, w_to;

   // start wins over a simultaneous write; that write is silently dropped
   assign w_start = r_state == IDLE && start && r_count != 5'd0;
   assign w_wr    = r_state == IDLE && tok_wr && !start;
   assign w_store = w_wr && tok_in <= 5'd20 && r_count != 5'd16;
   assign w_last  = {1'b0, r_idx} == r_count - 5'd1;
   assign w_tok   = r_buf[r_idx];

`ifdef EXPR_TX_TIMEOUT_EN
   logic [5:0] r_wd;
   logic       r_timeout;
   assign w_to    = r_state == WAIT && !valid_in && r_wd == 6'd63;
   assign timeout = r_timeout;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wd      <= 6'd0;
         r_timeout <= 1'b0;
      end else begin
         r_wd      <= r_state == WAIT ? r_wd + 6'd1 : 6'd0;
         r_timeout <= w_to;
      end
`else
   assign w_to    = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_start ? SEND : IDLE;
         SEND:    w_next = w_last ? TERM : SEND;
         TERM:    w_next = WAIT;
         WAIT:    w_next = valid_in ? DONE : w_to ? IDLE : WAIT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (w_store) r_buf[r_count[3:0]] <= tok_in;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_count  <= 5'd0;
         r_idx    <= 4'd0;
         r_result <= 7'd0;
         r_err    <= 1'b0;
      end else begin
         if (w_store) r_count <= r_count + 5'd1;
         if (r_state == DONE || w_to) r_count <= 5'd0;
         if (w_wr && !w_store) r_err <= 1'b1;
         if (w_start) r_err <= 1'b0;
         r_idx <= r_state == SEND ? r_idx + 4'd1 : 4'd0;
         if (r_state == WAIT && valid_in) r_result <= result_in;
      end

   always_comb begin
      ascii_out  = r_state == TERM ? 8'd61 :
                   r_state != SEND ? 8'd0 :
                   w_tok < 5'd10   ? 8'd48 + {3'b0, w_tok} :
                   w_tok < 5'd16   ? 8'd87 + {3'b0, w_tok} :
                   w_tok < 5'd20   ? 8'd24 + {3'b0, w_tok} : 8'd45;
      ready      = r_state == SEND && r_idx == 4'd0;
      busy       = r_state != IDLE;
      done       = r_state == DONE;
      result_out = r_result;
      err        = r_err;
   end
endmodule

// File: tb/tb_expr_tx.sv
// tb_expr_tx: directed scenarios for expr_tx with hand-computed character streams and results.
module tb_expr_tx;
   logic       clk = 0, rst = 1, tok_wr = 0, start = 0, valid_in = 0;
   logic [4:0] tok_in = 0;
   logic [6:0] result_in = 0;
   logic [7:0] ascii_out;
   logic       ready, busy, done, err, timeout;
   logic [6:0] result_out;
   int         n_chk = 0, n_fail = 0;

   expr_tx dut (
      .clk(clk), .rst(rst), .tok_wr(tok_wr), .tok_in(tok_in), .start(start),
      .ascii_out(ascii_out), .ready(ready), .valid_in(valid_in), .result_in(result_in),
      .busy(busy), .done(done), .result_out(result_out), .err(err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [4:0] c);
      tok_wr = 1; tok_in = c;
      @(negedge clk);
      tok_wr = 0;
   endtask

   task automatic go();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic test_reset();
      #3;
      n_chk++; if (ascii_out !== 8'd0) begin n_fail++; $display("FAIL rst_ascii: got %0d expected 0", ascii_out); end
      n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", ready); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
      n_chk++; if (result_out !== 7'd0) begin n_fail++; $display("FAIL rst_result: got %0d expected 0", result_out); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
      n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
      @(negedge clk);
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int e[$] = '{49, 43, 50, 61};
      wr(1); wr(19); wr(2);
      go();
      foreach (e[i]) begin
         n_chk++; if (ascii_out !== 8'(e[i])) begin n_fail++; $display("FAIL basic_char[%0d]: got %0d expected %0d", i, ascii_out, e[i]); end
         n_chk++; if (ready !== (i == 0)) begin n_fail++; $display("FAIL basic_ready[%0d]: got %b expected %b", i, ready, i == 0); end
         @(negedge clk);
      end
      n_chk++; if (ascii_out !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_wait: ascii %0d busy %b expected 0 1", ascii_out, busy); end
      valid_in = 1; result_in = 3;
      @(negedge clk);
      valid_in = 0;
      n_chk++; if (done !== 1'b1 || result_out !== 7'd3) begin n_fail++; $display("FAIL basic_done: done %b result %0d expected 1 3", done, result_out); end
      @(negedge clk);
      n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: done %b busy %b expected 0 0", done, busy); end
      valid_in = 1; result_in = 9;
      @(negedge clk);
      valid_in = 0;
      n_chk++; if (result_out !== 7'd3 || done !== 1'b0) begin n_fail++; $display("FAIL basic_valid_idle: result %0d done %b expected 3 0", result_out, done); end
   endtask

   task automatic test_mixed();
      int e[$] = '{40, 51, 45, 49, 41, 42, 102, 61};
      foreach (e[i]) if (i < 7) wr(5'(i == 0 ? 16 : i == 1 ? 3 : i == 2 ? 20 : i == 3 ? 1 : i == 4 ? 17 : i == 5 ? 18 : 15));
      go();
      foreach (e[i]) begin
         n_chk++; if (ascii_out !== 8'(e[i])) begin n_fail++; $display("FAIL mixed_char[%0d]: got %0d expected %0d", i, ascii_out, e[i]); end
         @(negedge clk);
      end
      tok_wr = 1; tok_in = 5; start = 1;
      for (int k = 0; k < 10; k++) begin
         n_chk++; if (busy !== 1'b1 || ascii_out !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL mixed_wait[%0d]: busy %b ascii %0d err %b expected 1 0 0", k, busy, ascii_out, err); end
         @(negedge clk);
      end
      tok_wr = 0; start = 0;
      valid_in = 1; result_in = 7;
      @(negedge clk);
      valid_in = 0;
      n_chk++; if (done !== 1'b1 || result_out !== 7'd7) begin n_fail++; $display("FAIL mixed_done: done %b result %0d expected 1 7", done, result_out); end
      @(negedge clk);
      wr(4);
      go();
      n_chk++; if (ascii_out !== 8'd52) begin n_fail++; $display("FAIL mixed_back2back: got %0d expected 52", ascii_out); end
      @(negedge clk);
      n_chk++; if (ascii_out !== 8'd61) begin n_fail++; $display("FAIL mixed_back2back_eq: got %0d expected 61", ascii_out); end
      @(negedge clk);
      valid_in = 1; result_in = 1;
      @(negedge clk);
      valid_in = 0;
      @(negedge clk);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) wr(5'(i));
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err16: got %b expected 0", err); end
      wr(0);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err17: got %b expected 1", err); end
      go();
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %b expected 0", err); end
      for (int i = 0; i < 17; i++) begin
         n_chk++; if (ascii_out !== 8'(i == 16 ? 61 : i < 10 ? 48 + i : 87 + i)) begin n_fail++; $display("FAIL ovf_char[%0d]: got %0d expected %0d", i, ascii_out, i == 16 ? 61 : i < 10 ? 48 + i : 87 + i); end
         @(negedge clk);
      end
      valid_in = 1; result_in = 85;
      @(negedge clk);
      valid_in = 0;
      n_chk++; if (done !== 1'b1 || result_out !== 7'd85) begin n_fail++; $display("FAIL ovf_done: done %b result %0d expected 1 85", done, result_out); end
      @(negedge clk);
   endtask

   task automatic test_invalid();
      wr(25);
      n_chk++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL inv_err: err %b busy %b expected 1 0", err, busy); end
      go();
      n_chk++; if (busy !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL inv_empty_start: busy %b err %b expected 0 1", busy, err); end
      tok_wr = 1; tok_in = 3; start = 1;
      @(negedge clk);
      tok_wr = 0; start = 0;
      n_chk++; if (busy !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL inv_empty_both: busy %b err %b expected 0 1", busy, err); end
      wr(7);
      tok_wr = 1; tok_in = 8; start = 1;
      @(negedge clk);
      tok_wr = 0; start = 0;
      n_chk++; if (ascii_out !== 8'd55 || ready !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL inv_prio: ascii %0d ready %b err %b expected 55 1 0", ascii_out, ready, err); end
      @(negedge clk);
      n_chk++; if (ascii_out !== 8'd61) begin n_fail++; $display("FAIL inv_prio_eq: got %0d expected 61", ascii_out); end
      @(negedge clk);
      valid_in = 1; result_in = 2;
      @(negedge clk);
      valid_in = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      wr(1); wr(2); wr(3); wr(4);
      go();
      @(negedge clk);
      n_chk++; if (ascii_out !== 8'd50) begin n_fail++; $display("FAIL rmid_char: got %0d expected 50", ascii_out); end
      rst = 1;
      #1;
      n_chk++; if (ascii_out !== 8'd0 || ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async: ascii %0d ready %b busy %b expected 0 0 0", ascii_out, ready, busy); end
      n_chk++; if (result_out !== 7'd0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rmid_regs: result %0d done %b err %b expected 0 0 0", result_out, done, err); end
      @(negedge clk);
      rst = 0;
      for (int k = 0; k < 6; k++) begin
         n_chk++; if (ascii_out !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet[%0d]: ascii %0d done %b busy %b expected 0 0 0", k, ascii_out, done, busy); end
         @(negedge clk);
      end
      wr(5);
      go();
      n_chk++; if (ascii_out !== 8'd53 || ready !== 1'b1) begin n_fail++; $display("FAIL rmid_restart: ascii %0d ready %b expected 53 1", ascii_out, ready); end
      @(negedge clk);
      n_chk++; if (ascii_out !== 8'd61) begin n_fail++; $display("FAIL rmid_restart_eq: got %0d expected 61", ascii_out); end
      @(negedge clk);
      valid_in = 1; result_in = 12;
      @(negedge clk);
      valid_in = 0;
      n_chk++; if (done !== 1'b1 || result_out !== 7'd12) begin n_fail++; $display("FAIL rmid_done: done %b result %0d expected 1 12", done, result_out); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      wr(9);
      go();
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 64; k++) begin
         n_chk++; if (busy !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d]: busy %b timeout %b expected 1 0", k, busy, timeout); end
         @(negedge clk);
      end
`ifdef EXPR_TX_TIMEOUT_EN
      n_chk++; if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL to_pulse: timeout %b busy %b done %b expected 1 0 0", timeout, busy, done); end
      @(negedge clk);
      n_chk++; if (timeout !== 1'b0 || result_out !== 7'd12) begin n_fail++; $display("FAIL to_after: timeout %b result %0d expected 0 12", timeout, result_out); end
      wr(6);
      go();
      n_chk++; if (ascii_out !== 8'd54) begin n_fail++; $display("FAIL to_restart: got %0d expected 54", ascii_out); end
      @(negedge clk);
      n_chk++; if (ascii_out !== 8'd61) begin n_fail++; $display("FAIL to_restart_eq: got %0d expected 61", ascii_out); end
      @(negedge clk);
`else
      for (int k = 0; k < 8; k++) begin
         n_chk++; if (busy !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_persist[%0d]: busy %b timeout %b expected 1 0", k, busy, timeout); end
         @(negedge clk);
      end
`endif
      valid_in = 1; result_in = 100;
      @(negedge clk);
      valid_in = 0;
      n_chk++; if (done !== 1'b1 || result_out !== 7'd100) begin n_fail++; $display("FAIL to_done: done %b result %0d expected 1 100", done, result_out); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mixed();
      test_overflow();
      test_invalid();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
